sdram_host_queue: RTL and testbench

//  Host-side request queue placed directly upstream of sdram_controller. Buffers host read and write

---
 rtl/sdram_host_pkg.sv | 23 ++
 rtl/sdram_req_fifo.sv | 68 ++++++
 rtl/sdram_host_queue.sv | 152 +++++++++++++++
 tb/tb_sdram_host_queue.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_host_pkg.sv
// sdram_host_pkg
//   Shared types for the SDRAM host request queue.
//   ADDR_W / DATA_W : host and controller address and data widths
//   state_t         : issue FSM states
//   cmd_t           : one queued host request (direction, address, write data)
package sdram_host_pkg;

   localparam int ADDR_W = 24;
   localparam int DATA_W = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } cmd_t;

endpackage

// File: rtl/sdram_req_fifo.sv
// sdram_req_fifo
//   In-order FIFO of host commands. The head entry is presented on dout
//   while the FIFO is not empty, so the consumer can pop and use it in the
//   same cycle. There is no bypass: an entry pushed in cycle N is first
//   visible on dout in cycle N+1.
// Ports
//   clk, rst : clock, asynchronous active-high reset (clears the pointers)
//   push/din : write din when push is high and the FIFO is not full
//   pop/dout : dout is the head; pop discards it when not empty
//   full     : DEPTH entries held
//   empty    : no entries held
module sdram_req_fifo
   import sdram_host_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic push,
   input  cmd_t din,
   input  logic pop,
   output cmd_t dout,
   output logic full,
   output logic empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

   cmd_t        mem_reg [DEPTH];
   logic [AW:0] wr_ptr_reg;
   logic [AW:0] rd_ptr_reg;
   logic        do_push;
   logic        do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // Pointers carry one extra wrap bit: equal low bits with differing wrap
   // bits means the write side has lapped the read side exactly once.
   assign empty = (wr_ptr_reg == rd_ptr_reg);
   assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                  (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

   assign dout = mem_reg[rd_ptr_reg[AW-1:0]];

   // Storage is not reset; only the pointers decide what is valid.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_reg[wr_ptr_reg[AW-1:0]] <= din;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
         end
         if (do_pop) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
         end
      end
   end

endmodule

// File: rtl/sdram_host_queue.sv
// sdram_host_queue
//   Host-side request queue in front of sdram_controller. Buffers host
//   reads and writes in order, issues one at a time on the controller's
//   enable/busy handshake, and returns read data as a one-cycle pulse.
// Ports
//   clk, rst              : clock, asynchronous active-high reset
//   req_valid/req_ready   : host request handshake (req_ready = !full)
//   req_we/addr/wdata     : host request (1 = write)
//   rsp_valid/rsp_data    : read response pulse, in request order
//   err                   : one-cycle pulse when a command is dropped
//                           because busy never rose within ACK_TIMEOUT
//   wr_addr/wr_data/wr_enable, rd_addr/rd_enable : controller command side
//   busy, rd_data, rd_ready                      : controller status side
module sdram_host_queue
   import sdram_host_pkg::*;
#(
   parameter int DEPTH       = 4,
   parameter int ACK_TIMEOUT = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_data,
   output logic              err,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              wr_enable,
   output logic [ADDR_W-1:0] rd_addr,
   output logic              rd_enable,
   input  logic              busy,
   input  logic [DATA_W-1:0] rd_data,
   input  logic              rd_ready
);

   localparam int               CNT_W    = $clog2(ACK_TIMEOUT) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t           state_reg;
   logic             cmd_we_reg;
   logic             got_rsp_reg;
   logic [CNT_W-1:0] cnt_reg;

   cmd_t req_cmd;
   cmd_t head;
   logic full;
   logic empty;
   logic pop;
   logic capture;

   assign req_ready = !full;
   assign req_cmd   = '{we: req_we, addr: req_addr, wdata: req_wdata};

   sdram_req_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (req_valid),
      .din   (req_cmd),
      .pop   (pop),
      .dout  (head),
      .full  (full),
      .empty (empty)
   );

   assign pop = (state_reg == IDLE) && !empty && !busy;

   // Read data is taken once per read: in WAIT, or in ISSUE on the same
   // cycle busy rises (the controller may strobe early on short accesses).
   assign capture = !cmd_we_reg && !got_rsp_reg && rd_ready &&
                    ((state_reg == WAIT) || ((state_reg == ISSUE) && busy));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg   <= IDLE;
         cmd_we_reg  <= 1'b0;
         got_rsp_reg <= 1'b0;
         cnt_reg     <= '0;
         wr_enable   <= 1'b0;
         rd_enable   <= 1'b0;
         wr_addr     <= '0;
         wr_data     <= '0;
         rd_addr     <= '0;
         rsp_valid   <= 1'b0;
         rsp_data    <= '0;
         err         <= 1'b0;
      end else begin
         rsp_valid <= 1'b0;
         err       <= 1'b0;

         if (capture) begin
            rsp_valid   <= 1'b1;
            rsp_data    <= rd_data;
            got_rsp_reg <= 1'b1;
         end

         case (state_reg)
            IDLE: begin
               // The popped head is loaded straight into the command
               // outputs so the enable is up on the very next cycle.
               if (pop) begin
                  cmd_we_reg  <= head.we;
                  got_rsp_reg <= 1'b0;
                  cnt_reg     <= '0;
                  wr_enable   <= head.we;
                  rd_enable   <= !head.we;
                  if (head.we) begin
                     wr_addr <= head.addr;
                     wr_data <= head.wdata;
                  end else begin
                     rd_addr <= head.addr;
                  end
                  state_reg <= ISSUE;
               end
            end

            ISSUE: begin
               if (busy) begin
                  wr_enable <= 1'b0;
                  rd_enable <= 1'b0;
                  state_reg <= WAIT;
               end else if (cnt_reg == CNT_LAST) begin
                  // Controller never acknowledged: drop the command.
                  wr_enable <= 1'b0;
                  rd_enable <= 1'b0;
                  err       <= 1'b1;
                  state_reg <= IDLE;
               end else begin
                  cnt_reg <= cnt_reg + CNT_ONE;
               end
            end

            WAIT: begin
               if (!busy && (cmd_we_reg || got_rsp_reg || capture)) begin
                  state_reg <= IDLE;
               end
            end

            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sdram_host_queue.sv
`timescale 1ns/1ps
module tb_sdram_host_queue;
   import sdram_host_pkg::*;

   logic              clk = 1'b0;
   logic              rst;
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_data;
   logic              err;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              wr_enable;
   logic [ADDR_W-1:0] rd_addr;
   logic              rd_enable;
   logic              busy     = 1'b0;
   logic [DATA_W-1:0] rd_data  = '0;
   logic              rd_ready = 1'b0;

   always #5 clk = ~clk;

   sdram_host_queue #(
      .DEPTH       (4),
      .ACK_TIMEOUT (8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .err       (err),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .wr_enable (wr_enable),
      .rd_addr   (rd_addr),
      .rd_enable (rd_enable),
      .busy      (busy),
      .rd_data   (rd_data),
      .rd_ready  (rd_ready)
   );

   // ---------------- controller model (acts on negedge) ----------------
   int lat        = 1;   // cycles from enable seen to busy high
   int hold       = 3;   // cycles busy stays high
   bit never_ack  = 1'b0;
   bit force_busy = 1'b0;
   bit dbl_pulse  = 1'b0;

   typedef enum {M_IDLE, M_LAT, M_BUSY} mst_t;
   mst_t              mst = M_IDLE;
   int                mcnt;
   bit                m_we;
   logic [ADDR_W-1:0] m_addr;
   logic [DATA_W-1:0] mem [logic [ADDR_W-1:0]];

   always @(negedge clk) begin
      if (rst) begin
         mst      = M_IDLE;
         busy     = 1'b0;
         rd_ready = 1'b0;
      end else begin
         case (mst)
            M_IDLE: begin
               rd_ready = 1'b0;
               busy     = force_busy;
               if (!force_busy && !never_ack && (wr_enable || rd_enable)) begin
                  m_we   = wr_enable;
                  m_addr = wr_enable ? wr_addr : rd_addr;
                  if (wr_enable) mem[wr_addr] = wr_data;
                  if (lat <= 1) begin
                     busy = 1'b1;
                     mcnt = hold;
                     mst  = M_BUSY;
                  end else begin
                     mcnt = lat - 1;
                     mst  = M_LAT;
                  end
               end
            end
            M_LAT: begin
               mcnt = mcnt - 1;
               if (mcnt == 0) begin
                  busy = 1'b1;
                  mcnt = hold;
                  mst  = M_BUSY;
               end
            end
            default: begin
               mcnt     = mcnt - 1;
               rd_ready = 1'b0;
               if (mcnt == 0) begin
                  busy = 1'b0;
                  mst  = M_IDLE;
               end else if (!m_we && (mcnt == 1 || (dbl_pulse && mcnt == 2))) begin
                  rd_ready = 1'b1;
                  rd_data  = mem.exists(m_addr) ? mem[m_addr] : 16'hdead;
               end
            end
         endcase
      end
   end

   // ---------------- monitor (negedge) ----------------
   typedef struct {
      bit                we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } log_t;

   log_t              cmd_log [$];
   int                len_q   [$];
   logic [DATA_W-1:0] rsp_q   [$];
   int                err_cnt = 0;
   int                en_len  = 0;
   bit                en_prev = 1'b0;
   bit                both_en = 1'b0;

   always @(negedge clk) begin
      if (wr_enable && rd_enable) both_en = 1'b1;
      if ((wr_enable || rd_enable) && !en_prev) begin
         cmd_log.push_back('{we: wr_enable,
                             addr: (wr_enable ? wr_addr : rd_addr),
                             data: (wr_enable ? wr_data : 16'h0)});
         en_len = 0;
      end
      if (wr_enable || rd_enable) en_len++;
      else if (en_prev) len_q.push_back(en_len);
      en_prev = wr_enable || rd_enable;
      if (rsp_valid) rsp_q.push_back(rsp_data);
      if (err) err_cnt++;
   end

   // ---------------- checking helpers ----------------
   int n_vec  = 0;
   int n_miss = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_miss++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
      $display("vec %0d %s observed %0h expected %0h", n_vec, tag, obs, exp);
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic push(input bit we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      bit done;
      done      = 1'b0;
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = a;
      req_wdata = d;
      for (int i = 0; i < 300 && !done; i++) begin
         if (req_ready) done = 1'b1;
         tick();
      end
      req_valid = 1'b0;
      chk("push_accepted", 32'(done), 32'd1);
   endtask

   task automatic wait_log(input int n);
      for (int i = 0; i < 500 && cmd_log.size() < n; i++) tick();
   endtask

   task automatic wait_rsp(input int n);
      for (int i = 0; i < 500 && rsp_q.size() < n; i++) tick();
   endtask

   int lb;
   int rb;
   int eb;
   int qb;

   initial begin
      rst       = 1'b1;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      mem[24'hbedfed] = 16'hbbbb;
      ticks(3);

      // reset state
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_wr_enable", 32'(wr_enable), 32'd0);
      chk("rst_rd_enable", 32'(rd_enable), 32'd0);
      chk("rst_wr_addr",   32'(wr_addr),   32'd0);
      chk("rst_wr_data",   32'(wr_data),   32'd0);
      chk("rst_rd_addr",   32'(rd_addr),   32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_data",  32'(rsp_data),  32'd0);
      chk("rst_err",       32'(err),       32'd0);
      rst = 1'b0;
      ticks(2);

      // 1: write, enable two cycles after accept, held until busy
      lat = 2; hold = 2;
      push(1'b1, 24'hfedbed, 16'h3333);
      chk("t1_en_cycle1", 32'(wr_enable), 32'd0);
      tick();
      chk("t1_wr_enable",  32'(wr_enable), 32'd1);
      chk("t1_wr_addr",    32'(wr_addr),   32'hfedbed);
      chk("t1_wr_data",    32'(wr_data),   32'h3333);
      chk("t1_rd_enable",  32'(rd_enable), 32'd0);
      tick();
      chk("t1_held",       32'(wr_enable), 32'd1);
      chk("t1_rd_enable2", 32'(rd_enable), 32'd0);
      tick();
      chk("t1_dropped",    32'(wr_enable), 32'd0);
      ticks(6);
      chk("t1_len", 32'(len_q[0]), 32'd2);

      // 2: read with two rd_ready strobes -> exactly one response
      lat = 1; hold = 4; dbl_pulse = 1'b1;
      lb = cmd_log.size(); rb = rsp_q.size();
      push(1'b0, 24'hbedfed, 16'h0);
      wait_rsp(rb + 1);
      ticks(10);
      chk("t2_rsp_count", 32'(rsp_q.size()), 32'(rb + 1));
      chk("t2_rsp_data",  32'(rsp_q[rb]), 32'hbbbb);
      chk("t2_cmd_we",    32'(cmd_log[lb].we), 32'd0);
      chk("t2_rd_addr",   32'(cmd_log[lb].addr), 32'hbedfed);
      dbl_pulse = 1'b0;

      // 3: busy held, fill the queue, 5th waits for first pop
      hold = 2;
      lb = cmd_log.size();
      force_busy = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) push(1'b1, 24'h100 + 24'(i), 16'h1000 + 16'(i));
      tick();
      chk("t3_full_ready", 32'(req_ready), 32'd0);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 24'h104; req_wdata = 16'h1004;
      tick();
      chk("t3_still_full", 32'(req_ready), 32'd0);
      chk("t3_no_issue",   32'(cmd_log.size()), 32'(lb));
      force_busy = 1'b0;
      push(1'b1, 24'h104, 16'h1004);
      wait_log(lb + 5);
      ticks(10);
      for (int i = 0; i < 5; i++) begin
         chk("t3_order_addr", 32'(cmd_log[lb + i].addr), 32'h100 + 32'(i));
         chk("t3_order_data", 32'(cmd_log[lb + i].data), 32'h1000 + 32'(i));
      end

      // 4: no acknowledge -> 8-cycle enable, err pulse, next command issued
      lb = cmd_log.size(); eb = err_cnt; qb = len_q.size();
      never_ack = 1'b1;
      push(1'b1, 24'h200, 16'h1111);
      push(1'b1, 24'h201, 16'h2222);
      for (int i = 0; i < 60 && err_cnt == eb; i++) tick();
      never_ack = 1'b0;
      wait_log(lb + 2);
      ticks(10);
      chk("t4_en_len",     32'(len_q[qb]), 32'd8);
      chk("t4_err_pulses", 32'(err_cnt - eb), 32'd1);
      chk("t4_first_addr", 32'(cmd_log[lb].addr), 32'h200);
      chk("t4_next_addr",  32'(cmd_log[lb + 1].addr), 32'h201);
      chk("t4_next_data",  32'(cmd_log[lb + 1].data), 32'h2222);

      // 5: mixed sequence, order and read data
      lat = 3; hold = 3;
      lb = cmd_log.size(); rb = rsp_q.size();
      push(1'b1, 24'h1, 16'haaaa);
      push(1'b0, 24'h1, 16'h0);
      push(1'b1, 24'h2, 16'h5555);
      push(1'b0, 24'h2, 16'h0);
      wait_rsp(rb + 2);
      ticks(10);
      chk("t5_we0",   32'(cmd_log[lb].we),       32'd1);
      chk("t5_we1",   32'(cmd_log[lb + 1].we),   32'd0);
      chk("t5_we2",   32'(cmd_log[lb + 2].we),   32'd1);
      chk("t5_we3",   32'(cmd_log[lb + 3].we),   32'd0);
      chk("t5_addr1", 32'(cmd_log[lb + 1].addr), 32'h1);
      chk("t5_addr3", 32'(cmd_log[lb + 3].addr), 32'h2);
      chk("t5_data2", 32'(cmd_log[lb + 2].data), 32'h5555);
      chk("t5_rsp_count", 32'(rsp_q.size()), 32'(rb + 2));
      chk("t5_rsp0",  32'(rsp_q[rb]),     32'haaaa);
      chk("t5_rsp1",  32'(rsp_q[rb + 1]), 32'h5555);

      // 6: reset during WAIT with three queued
      lat = 1; hold = 20;
      lb = cmd_log.size(); rb = rsp_q.size(); eb = err_cnt;
      push(1'b0, 24'h300, 16'h0);
      push(1'b1, 24'h301, 16'h3001);
      push(1'b1, 24'h302, 16'h3002);
      push(1'b1, 24'h303, 16'h3003);
      tick();
      rst = 1'b1;
      #1;
      chk("t6_wr_enable", 32'(wr_enable), 32'd0);
      chk("t6_rd_enable", 32'(rd_enable), 32'd0);
      tick();
      rst = 1'b0;
      tick();
      chk("t6_req_ready", 32'(req_ready), 32'd1);
      ticks(40);
      chk("t6_no_rsp",   32'(rsp_q.size()),   32'(rb));
      chk("t6_no_err",   32'(err_cnt),        32'(eb));
      chk("t6_no_issue", 32'(cmd_log.size()), 32'(lb + 1));

      // 7: reset while an enable is high drops it before the next edge
      hold = 2; eb = err_cnt;
      never_ack = 1'b1;
      push(1'b1, 24'h400, 16'h4444);
      tick();
      chk("t7_en_high", 32'(wr_enable), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("t7_async_drop", 32'(wr_enable), 32'd0);
      chk("t7_addr_clr",   32'(wr_addr),   32'd0);
      tick();
      rst = 1'b0;
      never_ack = 1'b0;
      ticks(20);
      chk("t7_no_err", 32'(err_cnt), 32'(eb));

      chk("never_both_enables", 32'(both_en), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
